// File: rtl/perm_sched_stage_if.sv
// Beat stream bundle between the bank read path, the scheduler and the permute network.
// Carries the control, input handshake and output handshake signals.
interface perm_sched_stage_if #(
   parameter int N      = 8,
   parameter int W      = 1,
   parameter int SELW   = 3,
   parameter int NSTAGE = 8
);
   localparam int STW = $clog2(NSTAGE) + 1;

   logic              start;
   logic              inv;
   logic              in_valid;
   logic              in_ready;
   logic [N*W-1:0]    in_bus;
   logic              out_valid;
   logic              out_ready;
   logic [N*W-1:0]    out_bus;
   logic [N*SELW-1:0] dest_bus;
   logic [STW-1:0]    out_stage;
   logic              out_last;
   logic              busy;
   logic              done;

   modport master (
      output start, inv, in_valid, in_bus, out_ready,
      input  in_ready, out_valid, out_bus, dest_bus,
      input  out_stage, out_last, busy, done
   );

   modport slave (
      input  start, inv, in_valid, in_bus, out_ready,
      output in_ready, out_valid, out_bus, dest_bus,
      output out_stage, out_last, busy, done
   );
endinterface

// File: rtl/perm_sched_stage.sv
// Scheduler ahead of the lane permutation network: tags each beat with
// stage-dependent lane destinations and buffers it in a 2-entry queue.
module perm_sched_stage #(
   parameter int N      = 8,
   parameter int W      = 1,
   parameter int SELW   = 3,
   parameter int NSTAGE = 8,
   parameter int GROUPS = 4
) (
   input  logic clk,
   input  logic rst_n,
   perm_sched_stage_if.slave bus
);
   localparam int LOGN = $clog2(N);
   localparam int STW  = $clog2(NSTAGE) + 1;
   localparam int GW   = (GROUPS > 1) ? $clog2(GROUPS) : 1;
   localparam logic [STW-1:0] SMAX = STW'(NSTAGE - 1);
   localparam logic [GW-1:0]  GMAX = GW'(GROUPS - 1);

   typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

   state_t            state_q, state_d;
   logic [GW-1:0]     grp_q, grp_d;
   logic [STW-1:0]    stg_q, stg_d;
   logic              inv_q, inv_d;

   logic [N*W-1:0]    q_data_q [2];
   logic [N*SELW-1:0] q_dest_q [2];
   logic [STW-1:0]    q_stg_q  [2];
   logic              q_last_q [2];
   logic              wp_q, rp_q;
   logic [1:0]        cnt_q;
   logic              done_q;

   logic              push, pop, last_in, in_rdy;
   logic [N*SELW-1:0] dest_d;
   logic [LOGN-1:0]   idx_w;
   logic [2*LOGN-1:0] dbl_w, sh_w;
   int                rot_w;

   assign in_rdy  = (state_q == RUN) && (cnt_q < 2'd2);
   assign push    = bus.in_valid && in_rdy;
   assign pop     = (cnt_q != 2'd0) && bus.out_ready;
   assign last_in = (stg_q == SMAX) && (grp_q == GMAX);

   assign bus.in_ready  = in_rdy;
   assign bus.out_valid = (cnt_q != 2'd0);
   assign bus.out_bus   = q_data_q[rp_q];
   assign bus.dest_bus  = q_dest_q[rp_q];
   assign bus.out_stage = q_stg_q[rp_q];
   assign bus.out_last  = q_last_q[rp_q];
   assign bus.busy      = (state_q != IDLE);
   assign bus.done      = done_q;

   // Per-lane destination: LOGN-bit rotate of the lane index by stage mod LOGN
   always_comb begin
      dest_d = '0;
      idx_w  = '0;
      dbl_w  = '0;
      sh_w   = '0;
      rot_w  = int'(stg_q) % LOGN;
      for (int i = 0; i < N; i++) begin
         idx_w = LOGN'(i);
         dbl_w = {idx_w, idx_w};
         if (inv_q) begin
            sh_w = dbl_w >> rot_w;
            dest_d[i*SELW +: LOGN] = sh_w[LOGN-1:0];
         end else begin
            sh_w = dbl_w << rot_w;
            dest_d[i*SELW +: LOGN] = sh_w[2*LOGN-1:LOGN];
         end
      end
   end

   // Next state for the transform FSM and its stage/group counters
   always_comb begin
      state_d = state_q;
      grp_d   = grp_q;
      stg_d   = stg_q;
      inv_d   = inv_q;
      unique case (state_q)
         IDLE: begin
            if (bus.start) begin
               state_d = RUN;
               grp_d   = '0;
               stg_d   = '0;
               inv_d   = bus.inv;
            end
         end
         RUN: begin
            if (push) begin
               if (last_in) begin
                  state_d = DRAIN;
               end else if (grp_q == GMAX) begin
                  grp_d = '0;
                  stg_d = stg_q + 1'b1;
               end else begin
                  grp_d = grp_q + 1'b1;
               end
            end
         end
         DRAIN: begin
            if (pop && q_last_q[rp_q]) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // FSM and counter registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         grp_q   <= '0;
         stg_q   <= '0;
         inv_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         grp_q   <= grp_d;
         stg_q   <= stg_d;
         inv_q   <= inv_d;
      end
   end

   // Two-entry elastic queue and the done pulse for the final beat
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int e = 0; e < 2; e++) begin
            q_data_q[e] <= '0;
            q_dest_q[e] <= '0;
            q_stg_q[e]  <= '0;
            q_last_q[e] <= 1'b0;
         end
         wp_q   <= 1'b0;
         rp_q   <= 1'b0;
         cnt_q  <= 2'd0;
         done_q <= 1'b0;
      end else begin
         if (push) begin
            q_data_q[wp_q] <= bus.in_bus;
            q_dest_q[wp_q] <= dest_d;
            q_stg_q[wp_q]  <= stg_q;
            q_last_q[wp_q] <= last_in;
            wp_q           <= ~wp_q;
         end
         if (pop) rp_q <= ~rp_q;
         cnt_q  <= cnt_q + 2'(push) - 2'(pop);
         done_q <= pop && q_last_q[rp_q];
      end
   end
endmodule

// File: tb/tb_perm_sched_stage.sv
// Directed bench for perm_sched_stage: rotation tables, backpressure,
// stage/group boundaries, ignored start and asynchronous reset.
module tb_perm_sched_stage;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   n_vec = 0;
   int   n_bad = 0;

   always #5 clk = ~clk;

   perm_sched_stage_if #(.N(8), .W(4), .SELW(3), .NSTAGE(3)) ifa ();
   perm_sched_stage_if #(.N(8), .W(4), .SELW(3), .NSTAGE(2)) ifb ();

   perm_sched_stage #(.N(8), .W(4), .SELW(3), .NSTAGE(3), .GROUPS(1)) dut_a (
      .clk(clk), .rst_n(rst_n), .bus(ifa.slave)
   );
   perm_sched_stage #(.N(8), .W(4), .SELW(3), .NSTAGE(2), .GROUPS(4)) dut_b (
      .clk(clk), .rst_n(rst_n), .bus(ifb.slave)
   );

   // hand-computed lane maps for N=8 (LOGN=3), indexed [stage mod 3][lane]
   int fwd_t [3][8] = '{'{0,1,2,3,4,5,6,7},
                        '{0,2,4,6,1,3,5,7},
                        '{0,4,1,5,2,6,3,7}};
   int inv_t [3][8] = '{'{0,1,2,3,4,5,6,7},
                        '{0,4,1,5,2,6,3,7},
                        '{0,2,4,6,1,3,5,7}};

   task automatic chk(input string tag, input logic [63:0] got,
                      input logic [63:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   function automatic logic [23:0] pk(input int s, input bit iv);
      logic [23:0] v;
      v = '0;
      for (int i = 0; i < 8; i++)
         v[i*3 +: 3] = iv ? 3'(inv_t[s][i]) : 3'(fwd_t[s][i]);
      return v;
   endfunction

   function automatic logic [31:0] dat(input logic [31:0] seed, input int b);
      return seed ^ (32'h1357_9BDF * (b + 1));
   endfunction

   // full 3-beat transform on dut_a, with a stray start mid-run
   task automatic xfer(input bit iv, input logic [31:0] seed);
      @(negedge clk);
      ifa.start = 1'b1; ifa.inv = iv; ifa.out_ready = 1'b1; ifa.in_valid = 1'b0;
      @(negedge clk);
      ifa.start = 1'b0; ifa.inv = ~iv;
      chk("x_busy", 64'(ifa.busy), 64'd1);
      chk("x_rdy", 64'(ifa.in_ready), 64'd1);
      for (int b = 0; b < 3; b++) begin
         ifa.in_valid = 1'b1;
         ifa.in_bus = dat(seed, b);
         ifa.start = (b == 1);
         @(negedge clk);
         ifa.start = 1'b0;
         chk("x_vld", 64'(ifa.out_valid), 64'd1);
         chk("x_data", 64'(ifa.out_bus), 64'(dat(seed, b)));
         chk("x_dest", 64'(ifa.dest_bus), 64'(pk(b, iv)));
         chk("x_stg", 64'(ifa.out_stage), 64'(b));
         chk("x_last", 64'(ifa.out_last), 64'(b == 2));
         chk("x_done0", 64'(ifa.done), 64'd0);
      end
      ifa.in_valid = 1'b0;
      chk("x_drain_rdy", 64'(ifa.in_ready), 64'd0);
      @(negedge clk);
      chk("x_done", 64'(ifa.done), 64'd1);
      chk("x_idle", 64'(ifa.busy), 64'd0);
      chk("x_empty", 64'(ifa.out_valid), 64'd0);
      @(negedge clk);
      chk("x_done_end", 64'(ifa.done), 64'd0);
   endtask

   initial begin
      ifa.start = 0; ifa.inv = 0; ifa.in_valid = 0; ifa.in_bus = '0; ifa.out_ready = 0;
      ifb.start = 0; ifb.inv = 0; ifb.in_valid = 0; ifb.in_bus = '0; ifb.out_ready = 0;
      repeat (2) @(negedge clk);
      chk("rst_rdy", 64'(ifa.in_ready), 64'd0);
      chk("rst_vld", 64'(ifa.out_valid), 64'd0);
      chk("rst_bus", 64'(ifa.out_bus), 64'd0);
      chk("rst_dest", 64'(ifa.dest_bus), 64'd0);
      chk("rst_stg", 64'(ifa.out_stage), 64'd0);
      chk("rst_last", 64'(ifa.out_last), 64'd0);
      chk("rst_busy", 64'(ifa.busy), 64'd0);
      chk("rst_done", 64'(ifa.done), 64'd0);
      rst_n = 1'b1;

      // in_valid while IDLE is refused
      @(negedge clk);
      ifa.in_valid = 1'b1; ifa.in_bus = 32'hDEAD_BEEF;
      chk("idle_rdy", 64'(ifa.in_ready), 64'd0);
      @(negedge clk);
      chk("idle_vld", 64'(ifa.out_valid), 64'd0);
      ifa.in_valid = 1'b0;

      xfer(1'b0, 32'h0F1E_2D3C);
      xfer(1'b1, 32'hA5C3_960F);

      // backpressure: two beats fill the queue, then in_ready drops
      @(negedge clk);
      ifa.start = 1'b1; ifa.inv = 1'b0; ifa.out_ready = 1'b0;
      @(negedge clk);
      ifa.start = 1'b0; ifa.in_valid = 1'b1; ifa.in_bus = 32'h1111_0000;
      @(negedge clk);
      chk("bp_rdy1", 64'(ifa.in_ready), 64'd1);
      chk("bp_head0", 64'(ifa.out_bus), 64'h1111_0000);
      ifa.in_bus = 32'h2222_0001;
      @(negedge clk);
      chk("bp_full", 64'(ifa.in_ready), 64'd0);
      ifa.in_bus = 32'h3333_0002;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         chk("bp_hold_rdy", 64'(ifa.in_ready), 64'd0);
         chk("bp_hold_bus", 64'(ifa.out_bus), 64'h1111_0000);
         chk("bp_hold_dest", 64'(ifa.dest_bus), 64'(pk(0, 1'b0)));
         chk("bp_hold_stg", 64'(ifa.out_stage), 64'd0);
      end
      ifa.out_ready = 1'b1;
      @(negedge clk);
      chk("bp_b1", 64'(ifa.out_bus), 64'h2222_0001);
      chk("bp_b1_stg", 64'(ifa.out_stage), 64'd1);
      chk("bp_b1_dest", 64'(ifa.dest_bus), 64'(pk(1, 1'b0)));
      chk("bp_reopen", 64'(ifa.in_ready), 64'd1);
      @(negedge clk);
      ifa.in_valid = 1'b0;
      chk("bp_b2", 64'(ifa.out_bus), 64'h3333_0002);
      chk("bp_b2_stg", 64'(ifa.out_stage), 64'd2);
      chk("bp_b2_last", 64'(ifa.out_last), 64'd1);
      @(negedge clk);
      chk("bp_done", 64'(ifa.done), 64'd1);
      chk("bp_empty", 64'(ifa.out_valid), 64'd0);

      // asynchronous reset with two beats queued
      @(negedge clk);
      ifa.start = 1'b1; ifa.out_ready = 1'b0;
      @(negedge clk);
      ifa.start = 1'b0; ifa.in_valid = 1'b1; ifa.in_bus = 32'h4444_0000;
      @(negedge clk);
      ifa.in_bus = 32'h5555_0001;
      @(negedge clk);
      ifa.in_valid = 1'b0;
      chk("ar_full_vld", 64'(ifa.out_valid), 64'd1);
      chk("ar_full_rdy", 64'(ifa.in_ready), 64'd0);
      #2 rst_n = 1'b0;
      #1;
      chk("ar_vld", 64'(ifa.out_valid), 64'd0);
      chk("ar_busy", 64'(ifa.busy), 64'd0);
      chk("ar_done", 64'(ifa.done), 64'd0);
      @(negedge clk);
      rst_n = 1'b1;
      ifa.out_ready = 1'b1;
      xfer(1'b0, 32'h6B6B_1234);

      // group/stage boundary on dut_b: GROUPS=4, NSTAGE=2
      @(negedge clk);
      ifb.start = 1'b1; ifb.inv = 1'b0; ifb.out_ready = 1'b1;
      @(negedge clk);
      ifb.start = 1'b0;
      for (int b = 0; b < 8; b++) begin
         ifb.in_valid = 1'b1;
         ifb.in_bus = dat(32'h7777_8888, b);
         @(negedge clk);
         chk("g_data", 64'(ifb.out_bus), 64'(dat(32'h7777_8888, b)));
         chk("g_stg", 64'(ifb.out_stage), 64'(b >= 4));
         chk("g_last", 64'(ifb.out_last), 64'(b == 7));
         chk("g_dest", 64'(ifb.dest_bus), 64'(pk((b >= 4) ? 1 : 0, 1'b0)));
      end
      ifb.in_valid = 1'b0;
      @(negedge clk);
      chk("g_done", 64'(ifb.done), 64'd1);
      chk("g_idle", 64'(ifb.busy), 64'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end
endmodule

// File: doc/perm_sched_stage.md
# perm_sched_stage

Streaming scheduler placed directly upstream of the lane permutation network. It accepts N-lane coefficient beats from the bank read path and attaches a per-lane destination vector to each beat. The vector is derived from the current NTT/INTT stage. The block counts stages and groups under a small FSM, buffers beats in a 2-entry elastic queue, and presents data plus destinations to the permute network with valid/ready flow control.

## Interface
- N, default 2*`P: lane count; power of two, ≥2; LOGN = $clog2(N).
- W, default 1: bits per lane.
- SELW, default `MAP: destination field width per lane; SELW ≥ LOGN.
- NSTAGE, default 8: stages per transform, ≥1.
- GROUPS, default 4: beats per stage, ≥1.
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle request to begin a transform; sampled in IDLE only.
- inv  in  1  transform direction, latched at start: 0 = forward, 1 = inverse.
- in_valid  in  1  upstream beat valid.
- in_ready  out  1  block can accept a beat.
- in_bus  in  N*W  lane data; lane i occupies [i*W +: W].
- out_valid  out  1  beat available for the permute network.
- out_ready  in  1  downstream accepts the beat.
- out_bus  out  N*W  lane data, unchanged from input.
- dest_bus  out  N*SELW  destination per lane; lane i occupies [i*SELW +: SELW].
- out_stage  out  $clog2(NSTAGE)+1  stage index of the presented beat.
- out_last  out  1  presented beat is the final beat of the transform.
- busy  out  1  FSM is not IDLE.
- done  out  1  one-cycle pulse when the final beat is accepted downstream.

## Operation
- FSM states and transitions:
  - IDLE → RUN on start: clear grp_cnt and stg_cnt; latch inv.
  - RUN → DRAIN when the last input beat is accepted (stg_cnt = NSTAGE-1, grp_cnt = GROUPS-1).
  - DRAIN → IDLE when the queue is empty after the final output handshake.
- start outside IDLE is ignored.
- Input accept: in_valid & in_ready. in_ready = (state == RUN) & (queue count < 2). in_ready is 0 in IDLE and in DRAIN.
- Counters advance only on input accept:
  - grp_cnt wraps GROUPS-1 → 0 and increments stg_cnt.
  - stg_cnt never exceeds NSTAGE-1.
- Destination for lane i is computed at accept from rot = stg_cnt mod LOGN:
  - Forward: dest[i] = LOGN-bit rotate-left of i by rot.
  - Inverse: dest[i] = LOGN-bit rotate-right of i by rot.
  - Bits above LOGN in each SELW field are zero.
  - The vector is always a permutation of 0..N-1.
- Queue entry contents: {data, dest vector, stage, last}. Entries are written on input accept and read on output accept, in FIFO order.
- Simultaneous accept and release with count = 2: not possible, because in_ready is 0 when full. With count = 1, both events occur and count stays 1.
- out_valid = (count > 0). Outputs are driven from the head entry.
- done pulses in the cycle after the output handshake of the out_last entry.

## Timing
- Reset values: in_ready 0, out_valid 0, out_bus 0, dest_bus 0, out_stage 0, out_last 0, busy 0, done 0. FSM in IDLE, counters 0, queue empty.
- Asynchronous reset mid-transform discards all queued beats immediately. No done pulse is issued.
- Start latency: start sampled in cycle t; busy = 1 and in_ready = 1 from cycle t+1.
- Data latency: a beat accepted in cycle t is presented (out_valid = 1) in cycle t+1 if the queue was empty.
- Throughput: one beat per cycle with out_ready held high.
- Output stability: out_bus, dest_bus, out_stage and out_last are held stable while out_valid & !out_ready.
- Transform length: exactly NSTAGE*GROUPS input beats. A new start is accepted in the cycle after done.

## Test plan
- Forward, N=8, NSTAGE=3, GROUPS=1, out_ready=1:
  - stage 0 dest = {0,1,2,3,4,5,6,7};
  - stage 1: lane1→2, lane4→1, lane5→3;
  - stage 2: lane1→4;
  - done one cycle after the third output handshake.
- Inverse, N=8, stage 1: lane1→4, lane2→1, lane6→3. Data lanes pass through unchanged.
- Backpressure: out_ready = 0 for 5 cycles while in_valid = 1.
  - Exactly 2 beats are accepted, then in_ready = 0.
  - Outputs stay stable; after release, beats emerge in order with no loss or duplication.
- Boundary, GROUPS=4, NSTAGE=2: beats 0–3 tagged stage 0, beats 4–7 tagged stage 1. out_last = 1 only on beat 7.
- start asserted during RUN is ignored. in_valid asserted in IDLE sees in_ready = 0 and no beat is accepted.
- rst_n pulled low with 2 beats queued: out_valid drops asynchronously, busy = 0. A subsequent start runs a clean transform.
